datapath_seq: RTL and testbench
===============================

Name: datapath_seq

Overview:
Parametrised, self-sequencing successor to the 16-bit datapath. It holds a register file of NREG×W words, A/B/C operand registers, a shifter, a 4-op ALU and an N/V/Z status register. A start/ready/done command interface drives an internal FSM, so the controller issues one command per operation instead of toggling loada/loadb/loadc/write itself. It sits between the instruction decoder/controller and memory.

Parameters:
W, 16, datapath word width (≥4)
NREG, 8, register count, power of 2; AW = clog2(NREG)
PCW, 9, program counter width (PCW ≤ W)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  command valid; accepted when start && ready
ready  out  1  high only in IDLE
op  in  2  ALUop: 00 add, 01 sub (A−B), 10 and, 11 not B
shift  in  2  00 none, 01 lsl1, 10 lsr1 (zero fill), 11 asr1
vsel  in  2  writeback source: 00 C, 01 PC zero-extended, 10 sximm8, 11 mdata
asel_zero  in  1  ALU A input forced to 0
bsel_imm  in  1  ALU B input = sximm5 instead of shifted B
set_flags  in  1  update status in EX
wb_en  in  1  write result to rd
rd, rn, rm  in  AW each  destination, A-source, B-source register
sximm5, sximm8, mdata  in  W each  data sources; sampled with the command
pc  in  PCW  program counter; sampled with the command
done  out  1  one-cycle pulse when the command completes
datapath_out  out  W  register C
N, V, Z  out  1 each  status register bits

Behaviour:
- Reset (async, rst_n=0): FSM→IDLE; all registers in the file, A, B, C and status = 0; done=0; ready=1 after release.
- On the accepting edge, all command fields are latched into a command register. Inputs are don't-care afterwards until the next accept.
- start while ready=0 is ignored. It is not queued.
- FSM states: IDLE, RA, RB, EX, WB.
  - IDLE→RA on accept if vsel=00.
  - IDLE→WB on accept if vsel≠00 (move; no ALU pass, C and status unchanged).
  - RA: A←rf[rn], then →RB.
  - RB: B←rf[rm], then →EX.
  - EX: C←ALU(Ain, Bin); status←flags if set_flags, then →WB.
  - WB: if wb_en, rf[rd]←selected source at the edge leaving WB; then →IDLE.
- done: registered, high for exactly the cycle after the WB edge, coinciding with IDLE. A new command may be accepted in that cycle.
- Latency, accept edge to done high: ALU command 5 cycles, move 2 cycles.
- Ain = asel_zero ? 0 : A. Bin = bsel_imm ? sximm5 : shift(B).
- Arithmetic is modulo 2^W.
- Flags:
  - Z = (result==0).
  - N = result[W−1].
  - V = signed overflow for add/sub (operand signs equal/differ and result sign differs from A); V=0 for and/not.
- rd may equal rn/rm. Reads occur in later states than the previous write, so no hazard logic is required.
- wb_en=0 with set_flags=1 is a compare: status updates, no register changes, C still updated.
- Reset asserted mid-command aborts it: no write, no done.

Decomposition:
- Package datapath_pkg: ALUop, shift and vsel encodings as localparams; FSM state enum; command struct (op, shift, vsel, flags, registers, immediates).
- One sub-module, regfile_param: W, NREG; one synchronous write port, one combinational read port; async active-low clear.
- ALU, shifter and the 4-input writeback mux stay inline.

Test Plan:
- Move/add: move sximm8=5→R0 and sximm8=3→R1; then add rd=R2, rn=R0, rm=R1 → done 5 cycles after accept, datapath_out=8, R2=8, Z=0, N=0.
- Overflow: R0=0x7FFF, R1=1, add with set_flags → C=0x8000, N=1, V=1, Z=0. Sub R0−R0 with set_flags, wb_en=0 → Z=1, R0 unchanged.
- Shifts: R3=0x8001 with shift=11, asel_zero=1, op=00 → C=0xC000. With shift=10 → C=0x4000. With shift=01 → C=0x0002.
- Handshake: pulse start during RB → ignored, ready=0. Start in the done cycle → accepted, back-to-back commands complete correctly.
- Reset mid-command: deassert rst_n during EX → all outputs 0 immediately, no done pulse, register file cleared, ready=1 after release.
- Parameter build: W=32, NREG=16, pc=0x1FF, move vsel=01 → R15=0x000001FF. mdata move (vsel=11) of 0xDEADBEEF → done 2 cycles after accept.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared encodings, FSM state type and command control payload
// for the self-sequencing datapath.
package datapath_pkg;

  // ALU operation encodings
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  // Shifter encodings
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // Writeback source encodings
  localparam logic [1:0] VS_C     = 2'b00;
  localparam logic [1:0] VS_PC    = 2'b01;
  localparam logic [1:0] VS_IMM8  = 2'b10;
  localparam logic [1:0] VS_MDATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RA   = 3'd1,
    S_RB   = 3'd2,
    S_EX   = 3'd3,
    S_WB   = 3'd4
  } state_t;

  // Width-independent control part of a command; the module wraps it with
  // the parameter-sized register indices and data fields.
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] shift;
    logic [1:0] vsel;
    logic       asel_zero;
    logic       bsel_imm;
    logic       set_flags;
    logic       wb_en;
  } ctrl_t;

endpackage

// File: rtl/regfile_param.sv
// regfile_param: NREG x W register file, one synchronous write port, one
// combinational read port, asynchronous active-low clear of every entry.
//   clk, rst_n          clock / async active-low clear
//   i_we, i_waddr,
//   i_wdata             write port (captured on rising edge)
//   i_raddr, o_rdata    combinational read port
module regfile_param #(
  parameter int unsigned W    = 16,
  parameter int unsigned NREG = 8,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [NREG];

  // Storage with whole-array clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: self-sequencing datapath. One accepted command runs
// IDLE->RA->RB->EX->WB (ALU op) or IDLE->WB (move), then pulses done.
//   clk, rst_n                    clock / async active-low reset
//   start, ready                  command handshake (accept = start & ready)
//   op, shift, vsel, asel_zero,
//   bsel_imm, set_flags, wb_en    command control fields
//   rd, rn, rm                    destination / A source / B source
//   sximm5, sximm8, mdata, pc     data sources, sampled on accept
//   done                          one-cycle completion pulse
//   datapath_out                  register C
//   N, V, Z                       status register
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned NREG = 8,
  parameter int unsigned PCW  = 9,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           ready,
  input  logic [1:0]     op,
  input  logic [1:0]     shift,
  input  logic [1:0]     vsel,
  input  logic           asel_zero,
  input  logic           bsel_imm,
  input  logic           set_flags,
  input  logic           wb_en,
  input  logic [AW-1:0]  rd,
  input  logic [AW-1:0]  rn,
  input  logic [AW-1:0]  rm,
  input  logic [W-1:0]   sximm5,
  input  logic [W-1:0]   sximm8,
  input  logic [W-1:0]   mdata,
  input  logic [PCW-1:0] pc,
  output logic           done,
  output logic [W-1:0]   datapath_out,
  output logic           N,
  output logic           V,
  output logic           Z
);

  typedef struct packed {
    ctrl_t          ctrl;
    logic [AW-1:0]  rd;
    logic [AW-1:0]  rn;
    logic [AW-1:0]  rm;
    logic [W-1:0]   sximm5;
    logic [W-1:0]   sximm8;
    logic [W-1:0]   mdata;
    logic [PCW-1:0] pc;
  } cmd_t;

  state_t       r_state, w_next;
  cmd_t         r_cmd, w_cmd_in;
  logic [W-1:0] r_a, r_b, r_c;
  logic         r_n, r_v, r_z, r_done;
  logic         w_accept, w_ld_a, w_ld_b, w_ld_c, w_we;
  logic [AW-1:0] w_raddr;
  logic [W-1:0] w_rdata, w_shb, w_ain, w_bin, w_alu, w_wb;
  logic         w_v;

  assign w_accept = start && (r_state == S_IDLE);

  // Command capture bundle
  always_comb begin
    w_cmd_in                = '0;
    w_cmd_in.ctrl.op        = op;
    w_cmd_in.ctrl.shift     = shift;
    w_cmd_in.ctrl.vsel      = vsel;
    w_cmd_in.ctrl.asel_zero = asel_zero;
    w_cmd_in.ctrl.bsel_imm  = bsel_imm;
    w_cmd_in.ctrl.set_flags = set_flags;
    w_cmd_in.ctrl.wb_en     = wb_en;
    w_cmd_in.rd             = rd;
    w_cmd_in.rn             = rn;
    w_cmd_in.rm             = rm;
    w_cmd_in.sximm5         = sximm5;
    w_cmd_in.sximm8         = sximm8;
    w_cmd_in.mdata          = mdata;
    w_cmd_in.pc             = pc;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and per-state load strobes
  always_comb begin
    w_next = r_state;
    w_ld_a = 1'b0;
    w_ld_b = 1'b0;
    w_ld_c = 1'b0;
    w_we   = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (vsel == VS_C) ? S_RA : S_WB;
      S_RA:   begin w_ld_a = 1'b1; w_next = S_RB; end
      S_RB:   begin w_ld_b = 1'b1; w_next = S_EX; end
      S_EX:   begin w_ld_c = 1'b1; w_next = S_WB; end
      S_WB:   begin w_we = r_cmd.ctrl.wb_en; w_next = S_IDLE; end
      default: w_next = S_IDLE;
    endcase
  end

  // Single read port is time-shared: rn in RA, rm in RB
  assign w_raddr = (r_state == S_RB) ? r_cmd.rm : r_cmd.rn;

  regfile_param #(.W(W), .NREG(NREG)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_cmd.rd),
    .i_wdata (w_wb),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Shifter on B
  always_comb begin
    w_shb = r_b;
    case (r_cmd.ctrl.shift)
      SH_LSL:  w_shb = {r_b[W-2:0], 1'b0};
      SH_LSR:  w_shb = {1'b0, r_b[W-1:1]};
      SH_ASR:  w_shb = {r_b[W-1], r_b[W-1:1]};
      default: w_shb = r_b;
    endcase
  end

  assign w_ain = r_cmd.ctrl.asel_zero ? '0 : r_a;
  assign w_bin = r_cmd.ctrl.bsel_imm ? r_cmd.sximm5 : w_shb;

  // ALU with signed-overflow detection for add/sub
  always_comb begin
    w_alu = '0;
    w_v   = 1'b0;
    case (r_cmd.ctrl.op)
      OP_ADD: begin
        w_alu = w_ain + w_bin;
        w_v   = (w_ain[W-1] == w_bin[W-1]) && (w_alu[W-1] != w_ain[W-1]);
      end
      OP_SUB: begin
        w_alu = w_ain - w_bin;
        w_v   = (w_ain[W-1] != w_bin[W-1]) && (w_alu[W-1] != w_ain[W-1]);
      end
      OP_AND:  w_alu = w_ain & w_bin;
      default: w_alu = ~w_bin;
    endcase
  end

  // Writeback source select
  always_comb begin
    w_wb = r_c;
    case (r_cmd.ctrl.vsel)
      VS_PC:    w_wb = W'(r_cmd.pc);
      VS_IMM8:  w_wb = r_cmd.sximm8;
      VS_MDATA: w_wb = r_cmd.mdata;
      default:  w_wb = r_c;
    endcase
  end

  // Command, operand, result and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_n    <= 1'b0;
      r_v    <= 1'b0;
      r_z    <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_accept) r_cmd <= w_cmd_in;
      if (w_ld_a)   r_a   <= w_rdata;
      if (w_ld_b)   r_b   <= w_rdata;
      if (w_ld_c) begin
        r_c <= w_alu;
        if (r_cmd.ctrl.set_flags) begin
          r_n <= w_alu[W-1];
          r_v <= w_v;
          r_z <= (w_alu == '0);
        end
      end
      r_done <= (r_state == S_WB);
    end
  end

  assign ready        = (r_state == S_IDLE);
  assign done         = r_done;
  assign datapath_out = r_c;
  assign N            = r_n;
  assign V            = r_v;
  assign Z            = r_z;

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq: a default 16-bit instance driven from
// a vector table plus handshake/reset sequences, and a W=32/NREG=16 instance.
module tb_datapath_seq;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  shift;
    logic [1:0]  vsel;
    logic        az;
    logic        bi;
    logic        sf;
    logic        wb;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [31:0] imm5;
    logic [31:0] imm8;
    logic [31:0] mdata;
    logic [8:0]  pc;
    int          lat;
    logic [31:0] c;
    logic [2:0]  f;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start16, start32;
  logic [1:0]  op, shift, vsel;
  logic        asel_zero, bsel_imm, set_flags, wb_en;
  logic [3:0]  rd, rn, rm;
  logic [31:0] sximm5, sximm8, mdata;
  logic [8:0]  pc;

  logic        ready16, done16, n16, v16, z16;
  logic [15:0] dout16;
  logic        ready32, done32, n32, v32, z32;
  logic [31:0] dout32;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  datapath_seq u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .ready(ready16),
    .op(op), .shift(shift), .vsel(vsel), .asel_zero(asel_zero),
    .bsel_imm(bsel_imm), .set_flags(set_flags), .wb_en(wb_en),
    .rd(rd[2:0]), .rn(rn[2:0]), .rm(rm[2:0]),
    .sximm5(sximm5[15:0]), .sximm8(sximm8[15:0]), .mdata(mdata[15:0]), .pc(pc),
    .done(done16), .datapath_out(dout16), .N(n16), .V(v16), .Z(z16)
  );

  datapath_seq #(.W(32), .NREG(16), .PCW(9)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .ready(ready32),
    .op(op), .shift(shift), .vsel(vsel), .asel_zero(asel_zero),
    .bsel_imm(bsel_imm), .set_flags(set_flags), .wb_en(wb_en),
    .rd(rd), .rn(rn), .rm(rm),
    .sximm5(sximm5), .sximm8(sximm8), .mdata(mdata), .pc(pc),
    .done(done32), .datapath_out(dout32), .N(n32), .V(v32), .Z(z32)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic rec_t alu(input logic [1:0] o, input logic [1:0] sh,
                               input logic az, input logic bi, input logic sf,
                               input logic wb, input int d, input int n, input int m,
                               input logic [31:0] imm5, input logic [31:0] c,
                               input logic [2:0] f);
    rec_t r;
    r = '0;
    r.op = o; r.shift = sh; r.vsel = 2'b00;
    r.az = az; r.bi = bi; r.sf = sf; r.wb = wb;
    r.rd = 4'(d); r.rn = 4'(n); r.rm = 4'(m);
    r.imm5 = imm5; r.lat = 5; r.c = c; r.f = f;
    return r;
  endfunction

  // Read a register into C without touching flags: C = 0 + rf[m]
  function automatic rec_t rdreg(input int m, input logic [31:0] c, input logic [2:0] f);
    return alu(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, m, 32'h0, c, f);
  endfunction

  function automatic rec_t mv(input logic [1:0] vs, input int d, input logic [31:0] val,
                              input logic [31:0] c, input logic [2:0] f);
    rec_t r;
    r = '0;
    r.vsel = vs; r.wb = 1'b1; r.rd = 4'(d);
    case (vs)
      2'b01:   r.pc = 9'(val);
      2'b10:   r.imm8 = val;
      default: r.mdata = val;
    endcase
    r.lat = 2; r.c = c; r.f = f;
    return r;
  endfunction

  task automatic drive(input rec_t r);
    op = r.op; shift = r.shift; vsel = r.vsel;
    asel_zero = r.az; bsel_imm = r.bi; set_flags = r.sf; wb_en = r.wb;
    rd = r.rd; rn = r.rn; rm = r.rm;
    sximm5 = r.imm5; sximm8 = r.imm8; mdata = r.mdata; pc = r.pc;
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or timeout)
  task automatic issue(input bit big, input rec_t r, output int lat,
                       output logic [31:0] c, output logic [2:0] f);
    chk("ready_before_start", 32'(big ? ready32 : ready16), 32'd1);
    drive(r);
    start16 = !big;
    start32 = big;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start16 = 1'b0;
    start32 = 1'b0;
    while (!(big ? done32 : done16) && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    c = big ? dout32 : {16'h0, dout16};
    f = big ? {n32, v32, z32} : {n16, v16, z16};
  endtask

  task automatic run_vec(input bit big, input int idx, input rec_t r);
    int lat;
    logic [31:0] c;
    logic [2:0] f;
    issue(big, r, lat, c, f);
    chk($sformatf("%s_v%0d_latency", big ? "w32" : "w16", idx), 32'(lat), 32'(r.lat));
    chk($sformatf("%s_v%0d_C", big ? "w32" : "w16", idx), c, r.c);
    chk($sformatf("%s_v%0d_NVZ", big ? "w32" : "w16", idx), 32'(f), 32'(r.f));
  endtask

  rec_t tbl[20];
  rec_t tbl32[4];

  initial begin
    int lat, k;
    logic [31:0] c;
    logic [2:0] f;
    bit seen;

    // ALU: op, shift, az, bi, sf, wb, rd, rn, rm, imm5, C, {N,V,Z}
    tbl[0]  = mv(2'b10, 0, 32'd5, 32'h0, 3'b000);
    tbl[1]  = mv(2'b10, 1, 32'd3, 32'h0, 3'b000);
    tbl[2]  = alu(2'b00, 2'b00, 0, 0, 0, 1, 2, 0, 1, 0, 32'h8, 3'b000);
    tbl[3]  = rdreg(2, 32'h8, 3'b000);
    tbl[4]  = mv(2'b10, 0, 32'h7FFF, 32'h8, 3'b000);
    tbl[5]  = mv(2'b10, 1, 32'h1, 32'h8, 3'b000);
    tbl[6]  = alu(2'b00, 2'b00, 0, 0, 1, 1, 4, 0, 1, 0, 32'h8000, 3'b110);
    tbl[7]  = alu(2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 3'b001);
    tbl[8]  = rdreg(0, 32'h7FFF, 3'b001);
    tbl[9]  = mv(2'b10, 3, 32'h8001, 32'h7FFF, 3'b001);
    tbl[10] = alu(2'b00, 2'b11, 1, 0, 1, 0, 0, 0, 3, 0, 32'hC000, 3'b100);
    tbl[11] = alu(2'b00, 2'b10, 1, 0, 1, 0, 0, 0, 3, 0, 32'h4000, 3'b000);
    tbl[12] = alu(2'b00, 2'b01, 1, 0, 1, 0, 0, 0, 3, 0, 32'h0002, 3'b000);
    tbl[13] = alu(2'b10, 2'b00, 0, 0, 1, 0, 0, 0, 3, 0, 32'h0001, 3'b000);
    tbl[14] = alu(2'b11, 2'b00, 0, 1, 1, 0, 0, 0, 0, 32'h0, 32'hFFFF, 3'b100);
    tbl[15] = alu(2'b01, 2'b00, 0, 0, 1, 0, 0, 4, 1, 0, 32'h7FFF, 3'b010);
    tbl[16] = mv(2'b11, 5, 32'hBEEF, 32'h7FFF, 3'b010);
    tbl[17] = rdreg(5, 32'hBEEF, 3'b010);
    tbl[18] = mv(2'b01, 6, 32'h1FF, 32'hBEEF, 3'b010);
    tbl[19] = rdreg(6, 32'h01FF, 3'b010);

    tbl32[0] = mv(2'b01, 15, 32'h1FF, 32'h0, 3'b000);
    tbl32[1] = rdreg(15, 32'h0000_01FF, 3'b000);
    tbl32[2] = mv(2'b11, 14, 32'hDEAD_BEEF, 32'h0000_01FF, 3'b000);
    tbl32[3] = alu(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 14, 0, 32'hDEAD_BEEF, 3'b100);

    rst_n = 1'b0;
    start16 = 1'b0;
    start32 = 1'b0;
    drive('0);
    repeat (2) @(negedge clk);
    chk("reset_C16", {16'h0, dout16}, 32'h0);
    chk("reset_NVZ16", 32'({n16, v16, z16}), 32'h0);
    chk("reset_done16", 32'(done16), 32'h0);
    chk("reset_C32", dout32, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready16_after_reset", 32'(ready16), 32'd1);
    chk("ready32_after_reset", 32'(ready32), 32'd1);

    // Back-to-back: each issue starts in the done cycle of the previous one
    for (int i = 0; i < 20; i++) run_vec(1'b0, i, tbl[i]);
    for (int i = 0; i < 4; i++)  run_vec(1'b1, i, tbl32[i]);

    // done is a single-cycle pulse
    @(negedge clk);
    chk("done_one_cycle", 32'(done16), 32'h0);

    // start during RB is ignored and does not queue
    drive(rdreg(2, 0, 0));
    start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_low_in_RB", 32'(ready16), 32'h0);
    drive(mv(2'b10, 7, 32'h1234, 0, 0));
    start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    k = 0;
    while (!done16 && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    chk("busy_cmd_done_seen", 32'(done16), 32'd1);
    chk("busy_cmd_C", {16'h0, dout16}, 32'h8);
    @(negedge clk);
    chk("ignored_start_no_queue", 32'(ready16 && !done16), 32'd1);
    run_vec(1'b0, 20, rdreg(7, 32'h0, 3'b010));

    // Reset asserted in EX aborts the command
    run_vec(1'b0, 21, rdreg(0, 32'h7FFF, 3'b010));
    drive(alu(2'b00, 2'b00, 0, 0, 1, 1, 2, 0, 1, 0, 0, 0));
    start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    chk("abort_C_cleared", {16'h0, dout16}, 32'h0);
    chk("abort_NVZ_cleared", 32'({n16, v16, z16}), 32'h0);
    chk("abort_done_low", 32'(done16), 32'h0);
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= done16; end
    rst_n = 1'b1;
    repeat (8) begin @(negedge clk); seen |= done16; end
    chk("abort_no_done_pulse", 32'(seen), 32'h0);
    chk("abort_ready_after_release", 32'(ready16), 32'd1);
    run_vec(1'b0, 22, rdreg(2, 32'h0, 3'b000));
    run_vec(1'b0, 23, rdreg(0, 32'h0, 3'b000));
    issue(1'b0, rdreg(3, 0, 0), lat, c, f);
    chk("abort_R3_cleared", c, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
